// File: rtl/fir_sched_pkg.sv
// Shared types and helpers for the round-robin 4-tap channel scheduler.
package fir_sched_pkg;

    typedef logic [2:0] fill_t;

    localparam fill_t FILL_FULL = 3'd4;

    // Width of a channel index; a lone bit is kept even for tiny channel counts.
    function automatic int chan_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fir4_chan_sched_csa4_add.sv
// Combinational 4-operand unsigned adder: two carry-save levels then one carry-propagate add.
module csa4_add #(
    parameter int W = 16
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic [W-1:0] i_c,
    input  logic [W-1:0] i_d,
    output logic [W+1:0] o_sum
);

    logic [W+1:0] w_a, w_b, w_c, w_d;
    logic [W+1:0] w_s1, w_c1, w_s2, w_c2;

    assign w_a = {2'b00, i_a};
    assign w_b = {2'b00, i_b};
    assign w_c = {2'b00, i_c};
    assign w_d = {2'b00, i_d};

    // The total never exceeds 4*(2^W-1), so bits shifted out of the carries are always zero.
    assign w_s1 = w_a ^ w_b ^ w_c;
    assign w_c1 = ((w_a & w_b) | (w_a & w_c) | (w_b & w_c)) << 1;
    assign w_s2 = w_s1 ^ w_c1 ^ w_d;
    assign w_c2 = ((w_s1 & w_c1) | (w_s1 & w_d) | (w_c1 & w_d)) << 1;

    assign o_sum = w_s2 + w_c2;

endmodule

// File: rtl/fir4_chan_sched.sv
// Round-robin scheduler sharing one 4-input adder across NCH sample channels.
// Optional FIR_WARMUP_MASK_EN suppresses outputs until a channel holds 4 samples.
module fir4_chan_sched
    import fir_sched_pkg::*;
#(
    parameter  int W   = 16,
    parameter  int NCH = 4,
    localparam int CW  = chan_w(NCH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NCH-1:0]     in_valid,
    input  logic [NCH*W-1:0]   in_data,
    output logic [NCH-1:0]     in_ready,
    input  logic [NCH-1:0]     chan_clear,
    output logic               out_valid,
    output logic [W+1:0]       out_data,
    output logic [CW-1:0]      out_chan,
    input  logic               out_ready
);

    logic                      w_stall;
    logic [NCH-1:0]            w_elig;
    logic [NCH-1:0]            w_grant;
    logic                      w_any;
    logic [CW-1:0]             w_gnt_idx;
    logic [CW:0]               w_try;
    logic [NCH-1:0][W-1:0]     w_in;
    logic [NCH-1:0][W-1:0]     w_h0, w_h1, w_h2;
    logic [W+1:0]              w_sum;
    logic                      w_emit;

    logic [CW-1:0]             r_ptr;
    logic                      r_out_valid;
    logic [W+1:0]              r_out_data;
    logic [CW-1:0]             r_out_chan;

    assign w_in     = in_data;
    assign w_stall  = r_out_valid & ~out_ready;
    assign w_elig   = in_valid & ~chan_clear & {NCH{~w_stall & ~reset}};
    assign in_ready = w_grant;

    // First eligible channel after the last granted one wins.
    always_comb begin
        w_any     = 1'b0;
        w_gnt_idx = '0;
        w_grant   = '0;
        w_try     = '0;
        for (int i = 1; i <= NCH; i++) begin
            w_try = {1'b0, r_ptr} + (CW+1)'(i);
            if (w_try >= (CW+1)'(NCH))
                w_try = w_try - (CW+1)'(NCH);
            if (!w_any && w_elig[w_try[CW-1:0]]) begin
                w_any     = 1'b1;
                w_gnt_idx = w_try[CW-1:0];
            end
        end
        if (w_any)
            w_grant[w_gnt_idx] = 1'b1;
    end

`ifdef FIR_WARMUP_MASK_EN
    fill_t [NCH-1:0] w_fill;
    fill_t           w_fill_post;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            logic [W-1:0] r_h0, r_h1, r_h2;

            always_ff @(posedge clk) begin
                if (reset || chan_clear[gi]) begin
                    r_h0 <= '0;
                    r_h1 <= '0;
                    r_h2 <= '0;
                end else if (w_grant[gi]) begin
                    r_h0 <= w_in[gi];
                    r_h1 <= r_h0;
                    r_h2 <= r_h1;
                end
            end

            assign w_h0[gi] = r_h0;
            assign w_h1[gi] = r_h1;
            assign w_h2[gi] = r_h2;

`ifdef FIR_WARMUP_MASK_EN
            fill_t r_fill;

            always_ff @(posedge clk) begin
                if (reset || chan_clear[gi])
                    r_fill <= '0;
                else if (w_grant[gi])
                    r_fill <= (r_fill == FILL_FULL) ? FILL_FULL : r_fill + 3'd1;
            end

            assign w_fill[gi] = r_fill;
`endif
        end
    endgenerate

    csa4_add #(.W(W)) u_add (
        .i_a   (w_in[w_gnt_idx]),
        .i_b   (w_h0[w_gnt_idx]),
        .i_c   (w_h1[w_gnt_idx]),
        .i_d   (w_h2[w_gnt_idx]),
        .o_sum (w_sum)
    );

`ifdef FIR_WARMUP_MASK_EN
    assign w_fill_post = (w_fill[w_gnt_idx] == FILL_FULL) ? FILL_FULL : w_fill[w_gnt_idx] + 3'd1;
    assign w_emit      = w_any && (w_fill_post == FILL_FULL);
`else
    assign w_emit      = w_any;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr       <= CW'(NCH-1);
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_chan  <= '0;
        end else begin
            if (w_any)
                r_ptr <= w_gnt_idx;
            if (w_emit) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_sum;
                r_out_chan  <= w_gnt_idx;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_chan  = r_out_chan;

endmodule

// File: tb/tb_fir4_chan_sched.sv
// Scoreboard bench for fir4_chan_sched: stimulus pushes expected sums, a monitor pops on accept.
module tb_fir4_chan_sched;

    localparam int W   = 16;
    localparam int NCH = 4;
    localparam int CW  = 2;

    logic               clk = 1'b0;
    logic               reset;
    logic [NCH-1:0]     in_valid;
    logic [NCH*W-1:0]   in_data;
    logic [NCH-1:0]     in_ready;
    logic [NCH-1:0]     chan_clear;
    logic               out_valid;
    logic [W+1:0]       out_data;
    logic [CW-1:0]      out_chan;
    logic               out_ready;

    always #5 clk = ~clk;

    fir4_chan_sched #(.W(W), .NCH(NCH)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .chan_clear (chan_clear),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_chan   (out_chan),
        .out_ready  (out_ready)
    );

    typedef struct packed {
        logic [CW-1:0] chan;
        logic [W+1:0]  data;
    } exp_t;

    int           n_tests = 0;
    int           n_fail  = 0;
    exp_t         sb[$];
    logic [W+1:0] acc_log[$];

    // Reference model: last four samples per channel, newest first.
    int m_hist [NCH][4];
    int m_cnt  [NCH];
    int m_ptr;
    bit m_ov;
    bit m_init     = 1'b0;
    bit m_rst_prev = 1'b0;

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                n_tests++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_out: got chan=%0d data=%0h, expected no output", out_chan, out_data);
                end else begin
                    e = sb.pop_front();
                    if (out_data !== e.data || out_chan !== e.chan) begin
                        n_fail++;
                        $display("FAIL out_sum: got chan=%0d data=%0h, expected chan=%0d data=%0h",
                                 out_chan, out_data, e.chan, e.data);
                    end else begin
                        $display("[TB] out chan=%0d data=%0h", out_chan, out_data);
                    end
                end
                acc_log.push_back(out_data);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [NCH*W-1:0] one_chan(input int k, input int val);
        logic [NCH*W-1:0] v;
        v = '0;
        v[k*W +: W] = W'(val);
        return v;
    endfunction

    task automatic step(input logic [NCH-1:0] v, input logic [NCH*W-1:0] d,
                        input logic [NCH-1:0] clr, input logic ordy, input logic rst);
        int   gidx;
        int   k;
        int   sum;
        bit   emit;
        logic [NCH-1:0] exp_g;
        @(posedge clk);
        #1;
        in_valid   = v;
        in_data    = d;
        chan_clear = clr;
        out_ready  = ordy;
        reset      = rst;
        #2;
        gidx  = -1;
        exp_g = '0;
        if (!rst && !(m_ov && !ordy)) begin
            for (int i = 1; i <= NCH; i++) begin
                k = (m_ptr + i) % NCH;
                if (gidx < 0 && v[k] && !clr[k])
                    gidx = k;
            end
        end
        if (gidx >= 0)
            exp_g[gidx] = 1'b1;
        check("in_ready", 32'(in_ready), 32'(exp_g));
        if (m_init)
            check("out_valid", 32'(out_valid), 32'(m_ov));
        if (m_rst_prev) begin
            check("rst_out_data", 32'(out_data), 32'd0);
            check("rst_out_chan", 32'(out_chan), 32'd0);
        end
        if (rst) begin
            for (int c = 0; c < NCH; c++) begin
                m_cnt[c] = 0;
                for (int j = 0; j < 4; j++) m_hist[c][j] = 0;
            end
            m_ptr = NCH - 1;
            m_ov  = 1'b0;
            m_init = 1'b1;
            sb.delete();
        end else begin
            if (gidx >= 0) begin
                for (int j = 3; j > 0; j--) m_hist[gidx][j] = m_hist[gidx][j-1];
                m_hist[gidx][0] = int'(d[gidx*W +: W]);
                m_cnt[gidx] = (m_cnt[gidx] >= 4) ? 4 : m_cnt[gidx] + 1;
                sum = m_hist[gidx][0] + m_hist[gidx][1] + m_hist[gidx][2] + m_hist[gidx][3];
`ifdef FIR_WARMUP_MASK_EN
                emit = (m_cnt[gidx] >= 4);
`else
                emit = 1'b1;
`endif
                if (emit)
                    sb.push_back('{chan: CW'(gidx), data: (W+2)'(sum)});
                m_ov  = emit;
                m_ptr = gidx;
            end else if (ordy) begin
                m_ov = 1'b0;
            end
            for (int c = 0; c < NCH; c++) begin
                if (clr[c]) begin
                    m_cnt[c] = 0;
                    for (int j = 0; j < 4; j++) m_hist[c][j] = 0;
                end
            end
        end
        m_rst_prev = rst;
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++)
            step('1, {$urandom, $urandom}, '0, 1'b0, 1'b1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step('0, '0, '0, 1'b1, 1'b0);
    endtask

    initial begin : stim
        logic [NCH-1:0]   v;
        logic [NCH-1:0]   clr;
        logic [NCH*W-1:0] d;
        logic             ordy;
        logic             rst;

        reset = 1'b1; in_valid = '0; in_data = '0; chan_clear = '0; out_ready = 1'b0;

        // Reset with all channels requesting, then a single channel ramp.
        do_reset(3);
        acc_log.delete();
        for (int s = 1; s <= 5; s++)
            step(4'b0001, one_chan(0, s), '0, 1'b1, 1'b0);
        idle(2);
`ifdef FIR_WARMUP_MASK_EN
        check("ramp_count", 32'(acc_log.size()), 32'd2);
        if (acc_log.size() == 2) begin
            check("ramp_0", 32'(acc_log[0]), 32'd10);
            check("ramp_1", 32'(acc_log[1]), 32'd14);
        end
`else
        check("ramp_count", 32'(acc_log.size()), 32'd5);
        if (acc_log.size() == 5) begin
            check("ramp_0", 32'(acc_log[0]), 32'd1);
            check("ramp_1", 32'(acc_log[1]), 32'd3);
            check("ramp_2", 32'(acc_log[2]), 32'd6);
            check("ramp_3", 32'(acc_log[3]), 32'd10);
            check("ramp_4", 32'(acc_log[4]), 32'd14);
        end
`endif

        // Fairness with every channel valid, then backpressure for 3 cycles.
        for (int i = 0; i < 16; i++)
            step('1, {$urandom, $urandom}, '0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++)
            step('1, {$urandom, $urandom}, '0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++)
            step('1, {$urandom, $urandom}, '0, 1'b1, 1'b0);
        idle(2);

        // Full-scale samples on channel 2.
        do_reset(1);
        acc_log.delete();
        for (int i = 0; i < 4; i++)
            step(4'b0100, one_chan(2, 'hFFFF), '0, 1'b1, 1'b0);
        idle(2);
`ifdef FIR_WARMUP_MASK_EN
        check("max_count", 32'(acc_log.size()), 32'd1);
`else
        check("max_count", 32'(acc_log.size()), 32'd4);
`endif
        if (acc_log.size() > 0)
            check("max_sum", 32'(acc_log[acc_log.size()-1]), 32'h3FFFC);

        // Clear wins over a same-cycle sample on channel 1.
        do_reset(1);
        for (int s = 7; s <= 9; s++)
            step(4'b0010, one_chan(1, s), '0, 1'b1, 1'b0);
        idle(2);
        acc_log.delete();
        step(4'b0010, one_chan(1, 99), 4'b0010, 1'b1, 1'b0);
        step(4'b0010, one_chan(1, 5), '0, 1'b1, 1'b0);
        idle(2);
`ifdef FIR_WARMUP_MASK_EN
        check("clear_count", 32'(acc_log.size()), 32'd0);
`else
        check("clear_count", 32'(acc_log.size()), 32'd1);
        if (acc_log.size() == 1)
            check("clear_sum", 32'(acc_log[0]), 32'd5);
`endif

        // Randomised traffic with clears, backpressure and occasional reset.
        for (int i = 0; i < 400; i++) begin
            v    = NCH'($urandom);
            d    = {$urandom, $urandom};
            clr  = ($urandom_range(0, 9) == 0) ? NCH'($urandom) : '0;
            rst  = ($urandom_range(0, 199) == 0);
            ordy = rst ? 1'b0 : ($urandom_range(0, 9) < 7);
            step(v, d, clr, ordy, rst);
        end
        idle(3);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
